// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand forwarding.
// ID-side WB bypass at capture; EX-side MEM/WB forwarding on the registered operands.
module id_ex_stage #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 4
) (
  input  logic           cpu_clk,
  input  logic           cpu_rst_n,
  input  logic           flush,
  input  logic           id_valid,
  input  logic [DW-1:0]  id_pc,
  input  logic [AW-1:0]  id_rs1,
  input  logic [AW-1:0]  id_rs2,
  input  logic [AW-1:0]  id_rd,
  input  logic [DW-1:0]  id_rD1,
  input  logic [DW-1:0]  id_rD2,
  input  logic [DW-1:0]  id_imm,
  input  logic [OPW-1:0] id_alu_op,
  input  logic           id_alub_sel,
  input  logic           id_rf_we,
  input  logic           id_mem_rd,
  input  logic           id_ram_we,
  input  logic [AW-1:0]  mem_rd,
  input  logic           mem_rf_we,
  input  logic [DW-1:0]  mem_fwd,
  input  logic [AW-1:0]  wb_rd,
  input  logic           wb_rf_we,
  input  logic [DW-1:0]  wb_wD,
  output logic           stall_id,
  output logic           ex_valid,
  output logic [DW-1:0]  ex_pc,
  output logic [AW-1:0]  ex_rd,
  output logic [DW-1:0]  ex_rD1,
  output logic [DW-1:0]  ex_rD2,
  output logic [DW-1:0]  ex_imm,
  output logic [OPW-1:0] ex_alu_op,
  output logic           ex_alub_sel,
  output logic           ex_rf_we,
  output logic           ex_mem_rd,
  output logic           ex_ram_we
);

  logic [AW-1:0] ex_rs1;
  logic [AW-1:0] ex_rs2;
  logic [DW-1:0] ex_op1;
  logic [DW-1:0] ex_op2;
  logic [DW-1:0] id_op1;
  logic [DW-1:0] id_op2;
  logic          luh;

  // A load in EX whose result ID needs cannot be forwarded in time.
  assign luh = id_valid & ex_valid & ex_mem_rd & (ex_rd != '0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign stall_id = luh & ~flush;

  // Regfile write and read in the same cycle: take the value being written.
  assign id_op1 = (wb_rf_we && wb_rd != '0 && wb_rd == id_rs1) ? wb_wD : id_rD1;
  assign id_op2 = (wb_rf_we && wb_rd != '0 && wb_rd == id_rs2) ? wb_wD : id_rD2;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_alu_op   <= '0;
      ex_alub_sel <= 1'b0;
      ex_rf_we    <= 1'b0;
      ex_mem_rd   <= 1'b0;
      ex_ram_we   <= 1'b0;
    end else if (flush || luh) begin
      // Bubble: only the control bits change, data fields keep their old contents.
      ex_valid  <= 1'b0;
      ex_rf_we  <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_ram_we <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rd       <= id_rd;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_op1      <= id_op1;
      ex_op2      <= id_op2;
      ex_imm      <= id_imm;
      ex_alu_op   <= id_alu_op;
      ex_alub_sel <= id_alub_sel;
      ex_rf_we    <= id_rf_we & id_valid;
      ex_mem_rd   <= id_mem_rd & id_valid;
      ex_ram_we   <= id_ram_we & id_valid;
    end
  end

  // MEM holds the newest value, so it wins over WB; x0 is never forwarded.
  always_comb begin
    ex_rD1 = ex_op1;
    if (mem_rf_we && mem_rd != '0 && mem_rd == ex_rs1)
      ex_rD1 = mem_fwd;
    else if (wb_rf_we && wb_rd != '0 && wb_rd == ex_rs1)
      ex_rD1 = wb_wD;

    ex_rD2 = ex_op2;
    if (mem_rf_we && mem_rd != '0 && mem_rd == ex_rs2)
      ex_rD2 = mem_fwd;
    else if (wb_rf_we && wb_rd != '0 && wb_rd == ex_rs2)
      ex_rD2 = wb_wD;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a reference model of the EX entry checked every cycle,
// plus directed hazard/forwarding scenarios with literal expectations.
module tb_id_ex_stage;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int OPW = 4;

  logic           cpu_clk;
  logic           cpu_rst_n;
  logic           flush;
  logic           id_valid;
  logic [DW-1:0]  id_pc;
  logic [AW-1:0]  id_rs1;
  logic [AW-1:0]  id_rs2;
  logic [AW-1:0]  id_rd;
  logic [DW-1:0]  id_rD1;
  logic [DW-1:0]  id_rD2;
  logic [DW-1:0]  id_imm;
  logic [OPW-1:0] id_alu_op;
  logic           id_alub_sel;
  logic           id_rf_we;
  logic           id_mem_rd;
  logic           id_ram_we;
  logic [AW-1:0]  mem_rd;
  logic           mem_rf_we;
  logic [DW-1:0]  mem_fwd;
  logic [AW-1:0]  wb_rd;
  logic           wb_rf_we;
  logic [DW-1:0]  wb_wD;
  logic           stall_id;
  logic           ex_valid;
  logic [DW-1:0]  ex_pc;
  logic [AW-1:0]  ex_rd;
  logic [DW-1:0]  ex_rD1;
  logic [DW-1:0]  ex_rD2;
  logic [DW-1:0]  ex_imm;
  logic [OPW-1:0] ex_alu_op;
  logic           ex_alub_sel;
  logic           ex_rf_we;
  logic           ex_mem_rd;
  logic           ex_ram_we;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_stage #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rD1(id_rD1), .id_rD2(id_rD2), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alub_sel(id_alub_sel), .id_rf_we(id_rf_we),
    .id_mem_rd(id_mem_rd), .id_ram_we(id_ram_we),
    .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .mem_fwd(mem_fwd),
    .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_wD(wb_wD),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_rD1(ex_rD1), .ex_rD2(ex_rD2), .ex_imm(ex_imm), .ex_alu_op(ex_alu_op),
    .ex_alub_sel(ex_alub_sel), .ex_rf_we(ex_rf_we), .ex_mem_rd(ex_mem_rd),
    .ex_ram_we(ex_ram_we)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Model of the instruction sitting in EX, in instruction terms.
  typedef struct {
    logic            valid;
    logic [DW-1:0]   pc;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [DW-1:0]   val1;
    logic [DW-1:0]   val2;
    logic [DW-1:0]   imm;
    logic [OPW-1:0]  op;
    logic            alub;
    logic            writes;
    logic            is_load;
    logic            is_store;
  } ex_entry_t;

  ex_entry_t m;

  function automatic ex_entry_t empty_entry();
    ex_entry_t e;
    e.valid = 0; e.pc = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.val1 = 0; e.val2 = 0;
    e.imm = 0; e.op = 0; e.alub = 0; e.writes = 0; e.is_load = 0; e.is_store = 0;
    return e;
  endfunction

  function automatic logic model_hazard(ex_entry_t e);
    return id_valid && e.valid && e.is_load && e.rd != 0 && (e.rd == id_rs1 || e.rd == id_rs2);
  endfunction

  function automatic logic [DW-1:0] newest_value(logic [AW-1:0] r, logic [DW-1:0] fallback,
                                                 logic use_mem);
    if (r == 0) return fallback;
    if (use_mem && mem_rf_we && mem_rd == r) return mem_fwd;
    if (wb_rf_we && wb_rd == r) return wb_wD;
    return fallback;
  endfunction

  function automatic ex_entry_t next_entry(ex_entry_t e);
    ex_entry_t n = e;
    if (flush || model_hazard(e)) begin
      n.valid = 0; n.writes = 0; n.is_load = 0; n.is_store = 0;
    end else begin
      n.valid    = id_valid;
      n.pc       = id_pc;
      n.rd       = id_rd;
      n.rs1      = id_rs1;
      n.rs2      = id_rs2;
      n.val1     = newest_value(id_rs1, id_rD1, 1'b0);
      n.val2     = newest_value(id_rs2, id_rD2, 1'b0);
      n.imm      = id_imm;
      n.op       = id_alu_op;
      n.alub     = id_alub_sel;
      n.writes   = id_rf_we && id_valid;
      n.is_load  = id_mem_rd && id_valid;
      n.is_store = id_ram_we && id_valid;
    end
    return n;
  endfunction

  always @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) m <= empty_entry();
    else            m <= next_entry(m);
  end

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // Compare the DUT to the model on every falling edge outside reset.
  always @(negedge cpu_clk) begin
    if (cpu_rst_n) begin
      check_output("model stall_id", stall_id, model_hazard(m) && !flush);
      check_output("model ex_valid", ex_valid, m.valid);
      check_output("model ex_rf_we", ex_rf_we, m.writes);
      check_output("model ex_mem_rd", ex_mem_rd, m.is_load);
      check_output("model ex_ram_we", ex_ram_we, m.is_store);
      if (m.valid) begin
        check_output("model ex_pc", ex_pc, m.pc);
        check_output("model ex_rd", ex_rd, m.rd);
        check_output("model ex_imm", ex_imm, m.imm);
        check_output("model ex_alu_op", ex_alu_op, m.op);
        check_output("model ex_alub_sel", ex_alub_sel, m.alub);
        check_output("model ex_rD1", ex_rD1, newest_value(m.rs1, m.val1, 1'b1));
        check_output("model ex_rD2", ex_rD2, newest_value(m.rs2, m.val2, 1'b1));
      end
    end
  end

  task automatic apply_stimulus(input logic v, input logic [DW-1:0] pc,
                                input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                input logic [AW-1:0] rd, input logic [DW-1:0] r1,
                                input logic [DW-1:0] r2, input logic [DW-1:0] imm,
                                input logic [OPW-1:0] op, input logic alub,
                                input logic we, input logic ld, input logic st);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rD1 = r1; id_rD2 = r2; id_imm = imm; id_alu_op = op; id_alub_sel = alub;
    id_rf_we = we; id_mem_rd = ld; id_ram_we = st;
  endtask

  task automatic apply_forward(input logic [AW-1:0] mrd, input logic mwe,
                               input logic [DW-1:0] mval, input logic [AW-1:0] wrd,
                               input logic wwe, input logic [DW-1:0] wval);
    mem_rd = mrd; mem_rf_we = mwe; mem_fwd = mval;
    wb_rd = wrd; wb_rf_we = wwe; wb_wD = wval;
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    flush = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_forward(0, 0, 0, 0, 0, 0);
    step();
    step();
    cpu_rst_n = 1'b1;

    // Async reset mid-cycle with a load in EX and a dependent op in ID.
    apply_stimulus(1, 32'h100, 1, 0, 3, 32'h40, 0, 4, 0, 1, 1, 1, 0);
    step();
    apply_stimulus(1, 32'h104, 3, 1, 4, 0, 32'h20, 0, 0, 0, 1, 0, 0);
    @(negedge cpu_clk);
    check_output("pre-reset stall_id", stall_id, 1);
    check_output("pre-reset ex_pc", ex_pc, 32'h100);
    #2 cpu_rst_n = 1'b0;
    #1;
    check_output("reset stall_id", stall_id, 0);
    check_output("reset ex_valid", ex_valid, 0);
    check_output("reset ex_pc", ex_pc, 0);
    check_output("reset ex_rd", ex_rd, 0);
    check_output("reset ex_rD1", ex_rD1, 0);
    check_output("reset ex_rD2", ex_rD2, 0);
    check_output("reset ex_imm", ex_imm, 0);
    check_output("reset ex_alu_op", ex_alu_op, 0);
    check_output("reset ex_alub_sel", ex_alub_sel, 0);
    check_output("reset ex_ctrl", {ex_rf_we, ex_mem_rd, ex_ram_we}, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    cpu_rst_n = 1'b1;

    // EX->EX forward: addi x5 then add x6,x5,x5.
    apply_stimulus(1, 32'h200, 0, 0, 5, 0, 0, 32'h10, 0, 1, 1, 0, 0);
    step();
    apply_stimulus(1, 32'h204, 5, 5, 6, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_forward(5, 1, 32'h10, 0, 0, 0);
    @(negedge cpu_clk);
    check_output("mem fwd ex_rD1", ex_rD1, 32'h10);
    check_output("mem fwd ex_rD2", ex_rD2, 32'h10);
    check_output("mem fwd ex_rd", ex_rd, 6);

    // MEM beats WB; then WB alone; then x0 never forwards.
    apply_forward(0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 32'h300, 7, 0, 8, 32'h1, 32'h2, 0, 3, 0, 1, 0, 0);
    step();
    apply_forward(7, 1, 32'hA, 7, 1, 32'hB);
    @(negedge cpu_clk);
    check_output("priority ex_rD1", ex_rD1, 32'hA);
    check_output("priority ex_rD2", ex_rD2, 32'h2);
    #1 mem_rf_we = 1'b0;
    #1;
    check_output("wb fwd ex_rD1", ex_rD1, 32'hB);
    apply_stimulus(1, 32'h304, 0, 0, 9, 32'h3, 32'h4, 0, 0, 0, 1, 0, 0);
    apply_forward(0, 1, 32'hA, 0, 1, 32'hB);
    step();
    @(negedge cpu_clk);
    check_output("x0 ex_rD1", ex_rD1, 32'h3);
    check_output("x0 ex_rD2", ex_rD2, 32'h4);

    // Load-use: lw x3 then add x4,x3,x1 -> one bubble, then WB forward.
    apply_forward(0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 32'h400, 1, 0, 3, 32'h100, 0, 4, 0, 1, 1, 1, 0);
    step();
    apply_stimulus(1, 32'h404, 3, 1, 4, 0, 32'h20, 0, 0, 0, 1, 0, 0);
    @(negedge cpu_clk);
    check_output("luh stall_id", stall_id, 1);
    step();
    @(negedge cpu_clk);
    check_output("bubble ex_valid", ex_valid, 0);
    check_output("bubble stall_id", stall_id, 0);
    check_output("bubble ex_rf_we", ex_rf_we, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_forward(0, 0, 0, 3, 1, 32'h77);
    @(negedge cpu_clk);
    check_output("after bubble ex_valid", ex_valid, 1);
    check_output("after bubble ex_pc", ex_pc, 32'h404);
    check_output("after bubble ex_rD1", ex_rD1, 32'h77);
    check_output("after bubble ex_rD2", ex_rD2, 32'h20);

    // Flush coinciding with a load-use hazard.
    apply_forward(0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 32'h500, 1, 0, 3, 0, 0, 8, 0, 1, 1, 1, 0);
    step();
    apply_stimulus(1, 32'h504, 3, 2, 4, 0, 0, 0, 0, 0, 1, 0, 0);
    flush = 1'b1;
    @(negedge cpu_clk);
    check_output("flush stall_id", stall_id, 0);
    step();
    flush = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge cpu_clk);
    check_output("flush ex_valid", ex_valid, 0);
    check_output("flush ex_rf_we", ex_rf_we, 0);

    // Regfile write of x9 in the same cycle ID reads it.
    apply_stimulus(1, 32'h600, 9, 0, 10, 0, 0, 0, 1, 0, 1, 0, 0);
    apply_forward(0, 0, 0, 9, 1, 32'h55);
    step();
    apply_forward(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge cpu_clk);
    check_output("wb bypass ex_rD1", ex_rD1, 32'h55);

    step();
    step();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
